// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: op encodings shared by the pipelined logic unit and its users.
package logic_unit_pkg;
    localparam int OP_W = 3;
    typedef enum logic [OP_W-1:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_XOR   = 3'd2,
        OP_NOR   = 3'd3,
        OP_NAND  = 3'd4,
        OP_XNOR  = 3'd5,
        OP_ANDN  = 3'd6,
        OP_PASSA = 3'd7
    } op_e;
endpackage

// File: rtl/logic_pipe_slice.sv
// logic_pipe_slice: one valid/ready register slice with fill-and-drain in the same cycle.
module logic_pipe_slice #(
    parameter int DW = 8,
    // MSB enables an async reset of the data register; low DW bits give its reset value
    parameter logic [DW:0] RESET_CFG = '0
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [DW-1:0] up_data,
    output logic          down_valid,
    input  logic          down_ready,
    output logic [DW-1:0] down_data
);
    assign up_ready = !down_valid || down_ready;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) down_valid <= 1'b0;
        else if (up_ready) down_valid <= up_valid;
    if (RESET_CFG[DW]) begin : g_rst
        always_ff @(posedge clock or negedge reset_n)
            if (!reset_n) down_data <= RESET_CFG[DW-1:0];
            else if (up_ready && up_valid) down_data <= up_data;
    end else begin : g_norst
        always_ff @(posedge clock)
            if (up_ready && up_valid) down_data <= up_data;
    end
endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: pipelined 8-op bitwise logic unit with zero/ones flags and full backpressure.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_ones,
    output logic [TAG_W-1:0] out_tag
);
    localparam int DW = WIDTH + TAG_W + 2;
    // Output slice resets to zero=1, ones=0, tag=0, result=0
    localparam logic [DW:0] OUT_RST = {2'b11, {(DW - 1){1'b0}}};

    if (STAGES < 1 || STAGES > 4 || WIDTH < 1) begin : g_bad_params
        $fatal(1, "logic_unit_pipe: STAGES must be 1..4 and WIDTH >= 1");
    end

    logic [WIDTH-1:0] res;
    logic [STAGES:0]  v;
    logic [STAGES:0]  r;
    logic [DW-1:0]    d [STAGES+1];

    always_comb begin
        case (op_e'(in_op))
            OP_AND:   res = in_a & in_b;
            OP_OR:    res = in_a | in_b;
            OP_XOR:   res = in_a ^ in_b;
            OP_NOR:   res = ~(in_a | in_b);
            OP_NAND:  res = ~(in_a & in_b);
            OP_XNOR:  res = ~(in_a ^ in_b);
            OP_ANDN:  res = in_a & ~in_b;
            OP_PASSA: res = in_a;
        endcase
    end

    assign v[0]      = in_valid;
    assign d[0]      = {~|res, &res, in_tag, res};
    assign in_ready  = r[0];
    assign r[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        logic_pipe_slice #(
            .DW(DW),
            .RESET_CFG(k == STAGES - 1 ? OUT_RST : '0)
        ) u_slice (
            .clock(clock),
            .reset_n(reset_n),
            .up_valid(v[k]),
            .up_ready(r[k]),
            .up_data(d[k]),
            .down_valid(v[k+1]),
            .down_ready(r[k+1]),
            .down_data(d[k+1])
        );
    end

    assign out_valid = v[STAGES];
    assign {out_zero, out_ones, out_tag, out_result} = d[STAGES];
endmodule
